// File: rtl/fig_pkg.sv
// Shared figure definitions for the board renderer, cursor logic and fig_overlay.
// Holds glyph encodings, the default coordinate width and a counter-width helper.
package fig_pkg;

    localparam int FIG_W = 11;

    typedef enum logic [1:0] {
        FIG_SOLID   = 2'd0,
        FIG_OUTLINE = 2'd1,
        FIG_X       = 2'd2,
        FIG_PLUS    = 2'd3
    } fig_mode_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned fig_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fig_blink.sv
// Frame-synchronous blink phase generator; one instance may drive several figures
// so that their blinking stays in step.
module fig_blink
    import fig_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic blink_en,
    input  logic frame_tick,
    output logic vis
);

    localparam int unsigned CW = fig_cnt_width(BLINK_FRAMES);
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] fcnt;

    // While disabled the counter idles at 0, so a tick arriving together with
    // the enable edge is counted as the first frame of the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
            vis  <= 1'b1;
        end else if (!blink_en) begin
            fcnt <= '0;
            vis  <= 1'b1;
        end else if (frame_tick) begin
            if (fcnt == LAST) begin
                fcnt <= '0;
                vis  <= ~vis;
            end else begin
                fcnt <= fcnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fig_overlay.sv
// Two-stage per-pixel figure generator: stage 1 localises the scan position to the
// cell, stage 2 evaluates the selected glyph and applies the blink phase.
module fig_overlay
    import fig_pkg::*;
#(
    parameter int W            = FIG_W,
    parameter int SIZE         = 64,
    parameter int THICK        = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] hcount,
    input  logic [W-1:0] vcount,
    input  logic [W-1:0] hmin,
    input  logic [W-1:0] vmin,
    input  logic         in_valid,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         blink_en,
    input  logic         frame_tick,
    output logic         out,
    output logic         out_valid
);

    // Geometry constants carried one bit wider so sums and differences cannot wrap.
    localparam logic [W:0] SZ   = (W+1)'(SIZE);
    localparam logic [W:0] SZM1 = (W+1)'(SIZE - 1);
    localparam logic [W:0] TK   = (W+1)'(THICK);
    localparam logic [W:0] EDGE = (W+1)'(SIZE - THICK);
    localparam logic [W:0] CLO  = (W+1)'((SIZE - THICK) / 2);
    localparam logic [W:0] CHI  = (W+1)'((SIZE - THICK) / 2 + THICK - 1);

    function automatic logic outline_hit(input logic [W:0] h, input logic [W:0] v);
        return (h < TK) || (h >= EDGE) || (v < TK) || (v >= EDGE);
    endfunction

    function automatic logic x_hit(input logic [W:0] h, input logic [W:0] v);
        logic [W:0] d;
        logic [W:0] s;
        logic [W:0] e;
        d = (h >= v) ? (h - v) : (v - h);
        s = h + v;
        e = (s >= SZM1) ? (s - SZM1) : (SZM1 - s);
        return (d < TK) || (e < TK);
    endfunction

    function automatic logic plus_hit(input logic [W:0] h, input logic [W:0] v);
        return ((h >= CLO) && (h <= CHI)) || ((v >= CLO) && (v <= CHI));
    endfunction

    function automatic logic glyph_hit(input fig_mode_e m, input logic [W:0] h,
                                       input logic [W:0] v);
        logic hit;
        case (m)
            FIG_SOLID:   hit = 1'b1;
            FIG_OUTLINE: hit = outline_hit(h, v);
            FIG_X:       hit = x_hit(h, v);
            FIG_PLUS:    hit = plus_hit(h, v);
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    logic [W-1:0] h_d;
    logic [W-1:0] v_d;
    logic         inside_d;

    logic [W-1:0] h_s1;
    logic [W-1:0] v_s1;
    logic         inside_s1;
    fig_mode_e    mode_s1;
    logic         en_s1;
    logic         valid_s1;

    logic         vis;
    logic         glyph_s1;

    // Left of / above the origin wraps to a large value and falls outside.
    always_comb begin
        h_d      = hcount - hmin;
        v_d      = vcount - vmin;
        inside_d = ({1'b0, h_d} < SZ) && ({1'b0, v_d} < SZ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_s1      <= '0;
            v_s1      <= '0;
            inside_s1 <= 1'b0;
            mode_s1   <= FIG_SOLID;
            en_s1     <= 1'b0;
            valid_s1  <= 1'b0;
        end else begin
            h_s1      <= h_d;
            v_s1      <= v_d;
            inside_s1 <= inside_d;
            mode_s1   <= fig_mode_e'(mode);
            en_s1     <= en;
            valid_s1  <= in_valid;
        end
    end

    always_comb begin
        glyph_s1 = glyph_hit(mode_s1, {1'b0, h_s1}, {1'b0, v_s1});
    end

    fig_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .blink_en   (blink_en),
        .frame_tick (frame_tick),
        .vis        (vis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out       <= en_s1 && inside_s1 && glyph_s1 && vis && valid_s1;
            out_valid <= valid_s1;
        end
    end

endmodule
